// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file; register 0 reads as zero and has no storage.
// Optional write-to-read bypass enabled by defining REG_FILE_BYPASS_EN.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [1:DEPTH-1];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  // Reset wins over a concurrent write; entry 0 is never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) begin
      rdata_a = mem[raddr_a];
`ifdef REG_FILE_BYPASS_EN
      // Bypass deliberately ignores rst: a matching read sees wdata even in a reset cycle.
      if (wr_en && (raddr_a == waddr)) begin
        rdata_a = wdata;
      end
`endif
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) begin
      rdata_b = mem[raddr_b];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (raddr_b == waddr)) begin
        rdata_b = wdata;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: reset clear, write/read, r0, hazard, reset priority, enable gating.
module tb_reg_file_2r1w;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;

  int checks = 0;
  int errors = 0;

  reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, reads settle #1 later.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] ra,
                            input logic [ADDR_W-1:0] rb,
                            input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
    raddr_a = ra; raddr_b = rb;
    #1;
    check({tag, "_a"}, rdata_a, ea);
    check({tag, "_b"}, rdata_b, eb);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

    // Initial reset: every register reads zero
    do_reset();
    read_check("reset_init", 5'd1, 5'd31, 32'h0, 32'h0);

    // Reset clear after a write
    do_write(5'd5, 32'hDEADBEEF);
    read_check("r5_written", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    do_reset();
    read_check("reset_clear", 5'd5, 5'd31, 32'h0, 32'h0);

    // Write/read, neighbour untouched
    do_write(5'd7, 32'h12345678);
    read_check("wr_rd", 5'd7, 5'd6, 32'h12345678, 32'h0);

    // r0 hardwired, including during the write itself
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    read_check("r0_during", 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    we = 1'b0;
    read_check("r0_after", 5'd0, 5'd0, 32'h0, 32'h0);

    // Same-cycle hazard on r9
    do_write(5'd9, 32'h1);
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h2;
`ifdef REG_FILE_BYPASS_EN
    read_check("hazard_pre", 5'd9, 5'd7, 32'h2, 32'h12345678);
`else
    read_check("hazard_pre", 5'd9, 5'd7, 32'h1, 32'h12345678);
`endif
    @(negedge clk);
    we = 1'b0;
    read_check("hazard_post", 5'd9, 5'd9, 32'h2, 32'h2);

    // Reset priority over a concurrent write; mid-operation clear
    @(negedge clk);
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    read_check("rst_prio", 5'd3, 5'd9, 32'h0, 32'h0);
    read_check("rst_mid", 5'd7, 5'd5, 32'h0, 32'h0);

    // Enable gating, then dual read of the same address
    @(negedge clk);
    we = 1'b0; waddr = 5'd4; wdata = 32'hCAFEF00D;
    @(negedge clk);
    read_check("we_gate", 5'd4, 5'd4, 32'h0, 32'h0);
    do_write(5'd4, 32'hCAFEF00D);
    read_check("dual_rd", 5'd4, 5'd4, 32'hCAFEF00D, 32'hCAFEF00D);

    // Back-to-back writes: last wins; top address boundary
    @(negedge clk);
    we = 1'b1; waddr = 5'd10; wdata = 32'h00000111;
    @(negedge clk);
    wdata = 32'h00000222;
    @(negedge clk);
    we = 1'b0;
    do_write(5'd31, 32'h80000001);
    read_check("b2b_top", 5'd10, 5'd31, 32'h00000222, 32'h80000001);
    read_check("indep", 5'd31, 5'd4, 32'h80000001, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
